// File: rtl/rv_pkg.sv
// Shared RV32 core definitions.
//   XLEN          architectural register / address width
//   NOP_INSTR     canonical no-op (addi x0, x0, 0) used as the idle fill value
//   fetch_state_e fetch sequencer states
package rv_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_stage_pc_gen.sv
// Program counter generator for the fetch stage.
// Holds the PC, advances it by 4 on a load, and takes an aligned redirect target.
// Also reports whether the current PC may be fetched without aliasing in memory.
// Ports:
//   clk, rst     clock / synchronous active-high reset
//   advance      a fetch was loaded this cycle: pc <= pc + 4
//   redirect_en  aligned redirect accepted this cycle: pc <= redirect_pc
//   redirect_pc  redirect target byte address
//   pc           current program counter
//   pc_legal     pc is word aligned and inside the instruction memory
module pc_gen
  import rv_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            advance,
  input  logic            redirect_en,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] pc,
  output logic            pc_legal
);

  localparam logic [XLEN-3:0] WORD_LIMIT = (XLEN-2)'(IMEM_WORDS);

  logic [XLEN-1:0] pc_p0;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_p0 <= RESET_PC;
    end else if (redirect_en) begin
      pc_p0 <= redirect_pc;
    end else if (advance) begin
      // Wraps modulo 2^32; a wrapped PC is caught by the range check anyway.
      pc_p0 <= pc_p0 + XLEN'(4);
    end
  end

  assign pc       = pc_p0;
  assign pc_legal = (pc_p0[1:0] == 2'b00) && (pc_p0[XLEN-1:2] < WORD_LIMIT);

endmodule

// File: rtl/fetch_stage.sv
// RV32 instruction-fetch stage.
// Drives the instruction memory address from the PC, registers {pc, instruction}
// into the IF/ID register with a valid/ready handshake toward decode, applies
// redirects from execute (squashing the wrong-path entry), and halts on an
// out-of-range PC or a misaligned redirect target.
// Ports:
//   clk, rst        clock / synchronous active-high reset
//   imem_addr       byte address to instruction memory (always equals pc)
//   imem_instr      instruction word returned combinationally for imem_addr
//   redirect_valid  execute requests a PC change this cycle
//   redirect_pc     redirect target byte address
//   out_valid       out_pc/out_instr hold a fetched instruction
//   out_ready       decode accepts the output this cycle
//   out_pc          PC of out_instr
//   out_instr       fetched instruction
//   halted          sticky: fetch has stopped
//   fetch_err       sticky: the halt was caused by a misaligned redirect
module fetch_stage
  import rv_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 64
) (
  input  logic            clk,
  input  logic            rst,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_instr,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_instr,
  output logic            halted,
  output logic            fetch_err
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc;
  logic            pc_legal;
  logic            load;
  logic            redirect_ok;
  logic            redirect_bad;
  logic            halt_now;
  logic            vld_d;

  logic            vld_p1;
  logic [XLEN-1:0] pc_p1;
  logic [XLEN-1:0] instr_p1;
  logic            halted_q;
  logic            fetch_err_q;

  pc_gen #(
    .RESET_PC   (RESET_PC),
    .IMEM_WORDS (IMEM_WORDS)
  ) u_pc_gen (
    .clk         (clk),
    .rst         (rst),
    .advance     (load),
    .redirect_en (redirect_ok),
    .redirect_pc (redirect_pc),
    .pc          (pc),
    .pc_legal    (pc_legal)
  );

  assign imem_addr = pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Redirect outranks everything; it is only honoured while running.
  always_comb begin
    state_d      = state_q;
    load         = 1'b0;
    redirect_ok  = 1'b0;
    redirect_bad = 1'b0;
    halt_now     = 1'b0;
    case (state_q)
      IDLE: state_d = RUN;
      RUN: begin
        if (redirect_valid) begin
          if (redirect_pc[1:0] == 2'b00) begin
            redirect_ok = 1'b1;
          end else begin
            redirect_bad = 1'b1;
            state_d      = HALT;
          end
        end else if (!pc_legal) begin
          halt_now = 1'b1;
          state_d  = HALT;
        end else if (!vld_p1 || out_ready) begin
          load = 1'b1;
        end
      end
      HALT: state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  // A redirect squashes the held entry even if decode is taking it this cycle.
  always_comb begin
    vld_d = vld_p1;
    if (redirect_ok || redirect_bad) begin
      vld_d = 1'b0;
    end else if (load) begin
      vld_d = 1'b1;
    end else if (out_ready) begin
      vld_d = 1'b0;
    end
  end

  // ---- IF/ID register (stage 1) ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1      <= 1'b0;
      pc_p1       <= '0;
      instr_p1    <= NOP_INSTR;
      halted_q    <= 1'b0;
      fetch_err_q <= 1'b0;
    end else begin
      vld_p1 <= vld_d;
      if (load) begin
        pc_p1    <= pc;
        instr_p1 <= imem_instr;
      end
      if (redirect_bad || halt_now) begin
        halted_q <= 1'b1;
      end
      if (redirect_bad) begin
        fetch_err_q <= 1'b1;
      end
    end
  end

  assign out_valid = vld_p1;
  assign out_pc    = pc_p1;
  assign out_instr = instr_p1;
  assign halted    = halted_q;
  assign fetch_err = fetch_err_q;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
  import rv_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        halted;
  logic        fetch_err;

  logic [31:0] mem [0:63];
  int          passed = 0;
  int          total  = 0;

  always #5 clk = ~clk;

  assign imem_instr = (imem_addr[31:8] == 24'h0) ? mem[imem_addr[7:2]] : 32'h0;

  fetch_stage #(.RESET_PC(32'h0000_0000), .IMEM_WORDS(64)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
    .halted         (halted),
    .fetch_err      (fetch_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset: two reset edges, then check every reset value and the IDLE cycle.
  task automatic test_reset();
    rst = 1'b1;
    out_ready = 1'b1;
    redirect_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    total++;
    if ({out_valid, out_pc, out_instr, halted, fetch_err, imem_addr} !==
        {1'b0, 32'h0, 32'h0000_0013, 1'b0, 1'b0, 32'h0}) begin
      $display("FAIL reset_state: got v=%0b pc=%h ins=%h h=%0b e=%0b a=%h", out_valid, out_pc,
               out_instr, halted, fetch_err, imem_addr);
    end else passed++;
    tick();
    total++;
    if (out_valid !== 1'b0) $display("FAIL idle_cycle: out_valid=%0b want 0", out_valid);
    else passed++;
  endtask

  task automatic test_stream();
    logic [31:0] exp_pc [0:2];
    exp_pc[0] = 32'h0; exp_pc[1] = 32'h4; exp_pc[2] = 32'h8;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if ({out_valid, out_pc, out_instr} !== {1'b1, exp_pc[i], mem[i]}) begin
        $display("FAIL stream_%0d: got v=%0b pc=%h ins=%h want pc=%h ins=%h", i, out_valid,
                 out_pc, out_instr, exp_pc[i], mem[i]);
      end else passed++;
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if ({out_valid, out_pc, out_instr, imem_addr} !== {1'b1, 32'h8, 32'h002081b3, 32'hC}) begin
        $display("FAIL stall_%0d: got v=%0b pc=%h ins=%h addr=%h want 8/002081b3/C", i,
                 out_valid, out_pc, out_instr, imem_addr);
      end else passed++;
    end
    out_ready = 1'b1;
    tick();
    total++;
    if ({out_valid, out_pc, out_instr} !== {1'b1, 32'hC, 32'h0020a233}) begin
      $display("FAIL stall_release: got v=%0b pc=%h ins=%h want C/0020a233", out_valid,
               out_pc, out_instr);
    end else passed++;
  endtask

  task automatic test_redirect();
    redirect_valid = 1'b1;
    redirect_pc = 32'h24;
    tick();
    redirect_valid = 1'b0;
    total++;
    if ({out_valid, imem_addr} !== {1'b0, 32'h24}) begin
      $display("FAIL redirect_squash: got v=%0b addr=%h want 0/24", out_valid, imem_addr);
    end else passed++;
    tick();
    total++;
    if ({out_valid, out_pc, out_instr} !== {1'b1, 32'h24, 32'h02a00413}) begin
      $display("FAIL redirect_target: got v=%0b pc=%h ins=%h want 24/02a00413", out_valid,
               out_pc, out_instr);
    end else passed++;
  endtask

  task automatic test_misaligned();
    redirect_valid = 1'b1;
    redirect_pc = 32'h22;
    tick();
    total++;
    if ({out_valid, halted, fetch_err, imem_addr} !== {1'b0, 1'b1, 1'b1, 32'h28}) begin
      $display("FAIL misaligned: got v=%0b h=%0b e=%0b addr=%h want 0/1/1/28", out_valid,
               halted, fetch_err, imem_addr);
    end else passed++;
    redirect_pc = 32'h0;
    tick();
    redirect_valid = 1'b0;
    tick();
    tick();
    total++;
    if ({out_valid, halted, fetch_err, imem_addr} !== {1'b0, 1'b1, 1'b1, 32'h28}) begin
      $display("FAIL halt_sticky: got v=%0b h=%0b e=%0b addr=%h want 0/1/1/28", out_valid,
               halted, fetch_err, imem_addr);
    end else passed++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if ({out_valid, halted, fetch_err, imem_addr} !== {1'b0, 1'b0, 1'b0, 32'h0}) begin
      $display("FAIL halt_clear: got v=%0b h=%0b e=%0b addr=%h want 0/0/0/0", out_valid,
               halted, fetch_err, imem_addr);
    end else passed++;
  endtask

  // Fetch the last legal word, then stop at the range boundary.
  task automatic test_range_end();
    tick();                       // IDLE -> RUN
    redirect_valid = 1'b1;
    redirect_pc = 32'hFC;
    tick();
    redirect_valid = 1'b0;
    total++;
    if ({out_valid, imem_addr} !== {1'b0, 32'hFC}) begin
      $display("FAIL range_redirect: got v=%0b addr=%h want 0/FC", out_valid, imem_addr);
    end else passed++;
    tick();
    total++;
    if ({out_valid, out_pc, out_instr, halted, imem_addr} !==
        {1'b1, 32'hFC, 32'h0010_0073, 1'b0, 32'h100}) begin
      $display("FAIL range_last: got v=%0b pc=%h ins=%h h=%0b addr=%h want 1/FC/00100073/0/100",
               out_valid, out_pc, out_instr, halted, imem_addr);
    end else passed++;
    tick();
    total++;
    if ({out_valid, halted, fetch_err, imem_addr} !== {1'b0, 1'b1, 1'b0, 32'h100}) begin
      $display("FAIL range_halt: got v=%0b h=%0b e=%0b addr=%h want 0/1/0/100", out_valid,
               halted, fetch_err, imem_addr);
    end else passed++;
    tick();
    tick();
    total++;
    if ({out_valid, halted} !== {1'b0, 1'b1}) begin
      $display("FAIL range_stay: got v=%0b h=%0b want 0/1", out_valid, halted);
    end else passed++;
  endtask

  task automatic test_reset_midflight();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();                       // IDLE
    tick();                       // load pc 0
    out_ready = 1'b0;
    tick();
    total++;
    if ({out_valid, out_pc} !== {1'b1, 32'h0}) begin
      $display("FAIL mid_setup: got v=%0b pc=%h want 1/0", out_valid, out_pc);
    end else passed++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if ({out_valid, halted, imem_addr, out_instr} !== {1'b0, 1'b0, 32'h0, 32'h0000_0013}) begin
      $display("FAIL mid_reset: got v=%0b h=%0b addr=%h ins=%h want 0/0/0/00000013", out_valid,
               halted, imem_addr, out_instr);
    end else passed++;
    tick();
    out_ready = 1'b1;
    total++;
    if (out_valid !== 1'b0) $display("FAIL mid_idle: out_valid=%0b want 0", out_valid);
    else passed++;
    tick();
    total++;
    if ({out_valid, out_pc, out_instr} !== {1'b1, 32'h0, 32'h00500093}) begin
      $display("FAIL mid_restart: got v=%0b pc=%h ins=%h want 1/0/00500093", out_valid,
               out_pc, out_instr);
    end else passed++;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[0]  = 32'h00500093;
    mem[1]  = 32'h00a00113;
    mem[2]  = 32'h002081b3;
    mem[3]  = 32'h0020a233;
    mem[9]  = 32'h02a00413;
    mem[63] = 32'h0010_0073;

    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_misaligned();
    test_range_end();
    test_reset_midflight();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
